// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared constants and types for the BBC Micro keyboard matrix model.
package keyboard_pkg;

  // Columns 0..9 carry real switches; 10..15 always read as released.
  localparam int NUM_COLS = 10;
  localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

  // BREAK is not part of the scanned matrix; it has its own line to the reset controller.
  localparam logic [3:0] BREAK_COL = 4'hF;
  localparam logic [2:0] BREAK_ROW = 3'h0;

  // Row 0 modifiers, visible only through PA7 (never through CA2).
  localparam logic [2:0] SHIFT_ROW = 3'h0;
  localparam logic [3:0] SHIFT_COL = 4'h0;
  localparam logic [2:0] CTRL_ROW  = 3'h0;
  localparam logic [3:0] CTRL_COL  = 4'h1;

  // Start-up link bits occupy row 0 from this column upward.
  localparam int FIRST_LINK_COL = 2;

  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
    logic       make;
  } key_event_t;

  // True when the column addresses a real switch column.
  function automatic logic col_in_matrix(input logic [3:0] col);
    return col <= LAST_COL;
  endfunction

endpackage

// File: rtl/keyboard_scan_counter.sv
// keyboard_scan_counter: the SCOL column counter. Free-runs in auto-scan,
// follows PORTA[3:0] in manual mode; only moves on the 1 MHz strobe.
module keyboard_scan_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       auto_scan,
  input  logic [3:0] load_col,
  output logic [3:0] scol,
  output logic [3:0] scol_next
);

  // Next column: increment (wrapping 15->0) or load, selected by the mode at the strobe.
  always_comb begin
    scol_next = scol;
    if (clk_en) begin
      scol_next = auto_scan ? scol + 4'd1 : load_col;
    end
  end

  // Column register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scol <= '0;
    end else begin
      scol <= scol_next;
    end
  end

endmodule

// File: rtl/keyboard_matrix.sv
// keyboard_matrix: 10x8 key switch matrix behind the system VIA, fed by
// make/break events over valid/ready, read back on PA7 and CA2.
// Optional feature macro: KBD_DIP_EN (start-up links OR'd into row 0, cols 2-9).
module keyboard_matrix #(
  parameter logic [7:0] DIP = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_en,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  input  logic [2:0] KEY_ROW,
  input  logic [3:0] KEY_COL,
  input  logic       KEY_MAKE,
  input  logic       KB_nEN,
  input  logic [6:0] PA_IN,
  output logic       PA7_OUT,
  output logic       CA2_OUT,
  output logic       BREAK_OUT
);
  import keyboard_pkg::*;

`ifdef KBD_DIP_EN
  localparam logic [7:0] LINK_MASK = 8'hFF;
`else
  localparam logic [7:0] LINK_MASK = 8'h00;
`endif
  // Links that actually reach PA7; all zero when the feature is built out.
  localparam logic [7:0] DIP_LINKS = DIP & LINK_MASK;

  key_event_t                   key_event;
  logic                         ready_reg;
  logic                         accept;
  logic                         break_reg;
  logic                         ca2_reg;
  logic [NUM_COLS-1:0][7:0]     key_state;
  logic [15:0]                  col_active;
  logic [15:0][7:0]             read_state;
  logic [3:0]                   scol;
  logic [3:0]                   scol_next;

  assign key_event = '{row: KEY_ROW, col: KEY_COL, make: KEY_MAKE};
  assign accept    = KEY_VALID & ready_reg;

  keyboard_scan_counter u_scan (
    .clk       (CLK),
    .rst       (RESET),
    .clk_en    (CLK_en),
    .auto_scan (KB_nEN),
    .load_col  (PA_IN[3:0]),
    .scol      (scol),
    .scol_next (scol_next)
  );

  // Handshake: ready drops for exactly the cycle following an acceptance.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= ~accept;
    end
  end

  // Key matrix update from accepted events; out-of-matrix columns are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_state <= '0;
    end else if (accept && col_in_matrix(key_event.col)) begin
      key_state[key_event.col][key_event.row] <= key_event.make;
    end
  end

  // BREAK key register, driven by the dedicated col 15 / row 0 event.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      break_reg <= 1'b0;
    end else if (accept && key_event.col == BREAK_COL && key_event.row == BREAK_ROW) begin
      break_reg <= key_event.make;
    end
  end

  // Per-column summaries: rows 1-7 for CA2, and the PA7 read view with links.
  for (genvar gi = 0; gi < 16; gi++) begin : g_col
    if (gi >= NUM_COLS) begin : g_empty
      assign col_active[gi] = 1'b0;
      assign read_state[gi] = '0;
    end else begin : g_real
      assign col_active[gi] = |key_state[gi][7:1];
      if (gi >= FIRST_LINK_COL) begin : g_link
        assign read_state[gi] = key_state[gi] | {7'b0, DIP_LINKS[gi - FIRST_LINK_COL]};
      end else begin : g_plain
        assign read_state[gi] = key_state[gi];
      end
    end
  end

  // CA2 samples the column SCOL is about to hold, using the pre-update matrix.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ca2_reg <= 1'b0;
    end else if (CLK_en) begin
      ca2_reg <= col_active[scol_next];
    end
  end

  assign PA7_OUT   = ~KB_nEN & read_state[PA_IN[3:0]][PA_IN[6:4]];
  assign CA2_OUT   = ca2_reg;
  assign BREAK_OUT = break_reg;
  assign KEY_READY = ready_reg;

endmodule

// File: tb/tb_keyboard_matrix.sv
// tb_keyboard_matrix: directed scenarios plus randomized traffic, checked every
// cycle against an array-based model of the keyboard.
module tb_keyboard_matrix;

  localparam logic [7:0] DIP_VAL = 8'h01;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLK_en = 1'b0;
  logic       KEY_VALID = 1'b0;
  logic       KEY_READY;
  logic [2:0] KEY_ROW = '0;
  logic [3:0] KEY_COL = '0;
  logic       KEY_MAKE = 1'b0;
  logic       KB_nEN = 1'b1;
  logic [6:0] PA_IN = '0;
  logic       PA7_OUT;
  logic       CA2_OUT;
  logic       BREAK_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit         mk[16][8];
  bit         exp_break;
  bit         exp_ready;
  bit         exp_ca2;
  logic [3:0] exp_scol;

  keyboard_matrix #(.DIP(DIP_VAL)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLK_en    (CLK_en),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY),
    .KEY_ROW   (KEY_ROW),
    .KEY_COL   (KEY_COL),
    .KEY_MAKE  (KEY_MAKE),
    .KB_nEN    (KB_nEN),
    .PA_IN     (PA_IN),
    .PA7_OUT   (PA7_OUT),
    .CA2_OUT   (CA2_OUT),
    .BREAK_OUT (BREAK_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++)
        mk[c][r] = 1'b0;
    exp_break = 1'b0;
    exp_ready = 1'b0;
    exp_ca2   = 1'b0;
    exp_scol  = 4'd0;
  endfunction

  // Any key held in rows 1..7 of a real column.
  function automatic bit col_any(input logic [3:0] col);
    bit any = 1'b0;
    if (col < 10)
      for (int r = 1; r < 8; r++)
        any |= mk[col][r];
    return any;
  endfunction

  function automatic bit exp_pa7();
    int c = PA_IN[3:0];
    int r = PA_IN[6:4];
    bit v = 1'b0;
    if (KB_nEN) return 1'b0;
    if (c < 10) v = mk[c][r];
`ifdef KBD_DIP_EN
    if (r == 0 && c >= 2 && c <= 9) v |= DIP_VAL[c-2];
`endif
    return v;
  endfunction

  // One clock: predict from pre-edge inputs, advance the model, compare outputs.
  task automatic tick(output bit acc);
    bit         en;
    logic [3:0] ns;
    acc = KEY_VALID && exp_ready;
    en  = CLK_en;
    ns  = KB_nEN ? exp_scol + 4'd1 : PA_IN[3:0];
    @(posedge CLK);
    if (en) begin
      exp_ca2  = col_any(ns);
      exp_scol = ns;
    end
    if (acc) begin
      if (KEY_COL < 10) mk[KEY_COL][KEY_ROW] = KEY_MAKE;
      else if (KEY_COL == 4'hF && KEY_ROW == 3'd0) exp_break = KEY_MAKE;
      $display("event row=%0d col=%0d make=%0d accepted at %0t", KEY_ROW, KEY_COL, KEY_MAKE, $time);
    end
    exp_ready = !acc;
    #1;
    check_eq("ready", KEY_READY, exp_ready);
    check_eq("ca2", CA2_OUT, exp_ca2);
    check_eq("break", BREAK_OUT, exp_break);
    check_eq("pa7", PA7_OUT, exp_pa7());
  endtask

  task automatic send_event(input logic [2:0] row, input logic [3:0] col, input logic make);
    bit acc = 1'b0;
    KEY_ROW = row; KEY_COL = col; KEY_MAKE = make; KEY_VALID = 1'b1;
    for (int i = 0; i < 4 && !acc; i++) tick(acc);
    KEY_VALID = 1'b0;
    check_eq("send_timeout", acc, 1'b1);
  endtask

  task automatic read_key(input string tag, input logic [2:0] row, input logic [3:0] col, input logic exp);
    PA_IN = {row, col};
    #1;
    check_eq(tag, PA7_OUT, exp);
  endtask

  // Run CLK_en periods of 4 cycles, counting periods in which CA2 is high.
  task automatic run_periods(input int periods, output int highs);
    bit acc;
    highs = 0;
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < 4; k++) begin
        CLK_en = (k == 0);
        tick(acc);
        if (k == 0 && CA2_OUT) highs++;
      end
    end
    CLK_en = 1'b0;
  endtask

  initial begin
    bit         acc;
    int         highs;
    int         idx;
    logic [4:0] pat;
    logic [2:0] ev_row[3];
    logic [3:0] ev_col[3];

    // Reset
    model_reset();
    #1;
    check_eq("rst_ready_held", KEY_READY, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check_eq("rst_ca2", CA2_OUT, 1'b0);
    check_eq("rst_pa7", PA7_OUT, 1'b0);
    check_eq("rst_break", BREAK_OUT, 1'b0);
    check_eq("rst_ready_low", KEY_READY, 1'b0);
    check_eq("rst_scol", dut.scol, 4'd0);
    tick(acc);
    check_eq("rst_ready_rise", KEY_READY, 1'b1);

    // Manual read
    KB_nEN = 1'b0;
    PA_IN  = 7'h43;
    #1;
    check_eq("man_before", PA7_OUT, 1'b0);
    send_event(3'd4, 4'd3, 1'b1);
    check_eq("man_read", PA7_OUT, 1'b1);
    read_key("man_other", 3'd4, 4'd4, 1'b0);

    // Auto-scan
    send_event(3'd4, 4'd3, 1'b0);
    KB_nEN = 1'b1;
    send_event(3'd2, 4'd7, 1'b1);
    run_periods(32, highs);
    check_eq("auto_ca2_count", highs, 2);
    send_event(3'd2, 4'd7, 1'b0);
    run_periods(16, highs);
    check_eq("auto_released", highs, 0);

    // Row 0 and links
    send_event(3'd0, 4'd0, 1'b1);
    run_periods(16, highs);
    check_eq("shift_no_ca2", highs, 0);
    KB_nEN = 1'b0;
`ifdef KBD_DIP_EN
    read_key("dip_link", 3'd0, 4'd2, 1'b1);
`else
    read_key("dip_link", 3'd0, 4'd2, 1'b0);
`endif
    read_key("shift_read", 3'd0, 4'd0, 1'b1);

    // Back-to-back events
    ev_row = '{3'd1, 3'd6, 3'd3};
    ev_col = '{4'd5, 4'd9, 4'd0};
    idx = 0;
    KEY_ROW = ev_row[0]; KEY_COL = ev_col[0]; KEY_MAKE = 1'b1; KEY_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pat[4-i] = KEY_READY;
      tick(acc);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          KEY_ROW = ev_row[idx]; KEY_COL = ev_col[idx];
        end else begin
          KEY_VALID = 1'b0;
        end
      end
    end
    KEY_VALID = 1'b0;
    check_eq("b2b_ready", pat, 5'b10101);
    read_key("b2b_ev0", 3'd1, 4'd5, 1'b1);
    read_key("b2b_ev1", 3'd6, 4'd9, 1'b1);
    read_key("b2b_ev2", 3'd3, 4'd0, 1'b1);

    // Invalid column and BREAK
    send_event(3'd2, 4'd12, 1'b1);
    read_key("col12_read", 3'd2, 4'd12, 1'b0);
    send_event(3'd0, 4'hF, 1'b1);
    check_eq("break_set", BREAK_OUT, 1'b1);
    send_event(3'd0, 4'hF, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!(KEY_VALID && !exp_ready)) begin
        KEY_VALID = 1'($urandom_range(0, 1));
        KEY_ROW   = 3'($urandom);
        KEY_COL   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
        KEY_MAKE  = ($urandom_range(0, 2) != 0);
      end
      CLK_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) KB_nEN = ~KB_nEN;
      PA_IN = 7'($urandom);
      tick(acc);
    end
    CLK_en = 1'b0;
    KEY_VALID = 1'b0;
    tick(acc);

    // Reset mid-handshake
    KB_nEN = 1'b0;
    PA_IN = {3'd5, 4'd8};
    KEY_ROW = 3'd5; KEY_COL = 4'd8; KEY_MAKE = 1'b1; KEY_VALID = 1'b1;
    tick(acc);
    check_eq("mid_accepted", acc, 1'b1);
    check_eq("mid_pa7_set", PA7_OUT, 1'b1);
    RESET = 1'b1;
    #1;
    model_reset();
    check_eq("mid_cleared", PA7_OUT, 1'b0);
    check_eq("mid_ready", KEY_READY, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    KEY_VALID = 1'b0;
    tick(acc);
    tick(acc);
    check_eq("mid_not_applied", PA7_OUT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_matrix.md
# keyboard_matrix

Models the BBC Micro keyboard matrix behind the system VIA: 10 columns × 8 rows of key switches, the free-running column scanner, and the PA7/CA2 return lines. Upstream, a PS/2 decoder delivers key make/break events over a valid/ready handshake. Downstream, the system VIA reads the key state on PORTA bit 7 and receives a keypress interrupt on CA2. The keyboard enable (addressable latch bit 3) selects auto-scan or manual interrogation.

## Interface
- `DIP`, default 8'h00: start-up link settings on row 0, columns 2–9 (bit n maps to column n+2). Only used with `KBD_DIP_EN`.
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `CLK_en` in 1: 1 MHz strobe, the same one the VIAs use.
- `KEY_VALID` in 1: event offered.
- `KEY_READY` out 1: event accepted when `KEY_VALID & KEY_READY` are both high at a CLK edge.
- `KEY_ROW` in 3: row of the event.
- `KEY_COL` in 4: column of the event.
- `KEY_MAKE` in 1: 1 = press, 0 = release.
- `KB_nEN` in 1: 0 = manual mode, 1 = auto-scan.
- `PA_IN` in 7: VIA PORTA[6:0]. [3:0] is the column, [6:4] is the row.
- `PA7_OUT` out 1: state of the addressed key.
- `CA2_OUT` out 1: any key pressed in rows 1–7 of the current column.
- `BREAK_OUT` out 1: BREAK key held; goes to the reset controller.

## Operation
- **Key state.** The matrix is an 80-bit register indexed `{col,row}`. Columns 10–15 read as all-released.
- **Event handling**
  - An accepted event with col ≤ 9 sets the key bit (make) or clears it (break).
  - Col = 15, row = 0 is the BREAK key: it sets or clears the `BREAK_OUT` register.
  - All other col ≥ 10 events are accepted and discarded.
  - A repeated make or break is idempotent.
- **Handshake.** `KEY_READY` is 1 except in the single cycle after an acceptance, when it is 0. The sustained rate is one event per 2 cycles. `KEY_VALID` with `KEY_READY` low holds the event; the source must not change it.
- **Column counter.** 4-bit `SCOL`.
  - Auto-scan (`KB_nEN`=1): increments on each `CLK_en` and wraps 15→0.
  - Manual (`KB_nEN`=0): loads `PA_IN[3:0]` on each `CLK_en`.
- **CA2_OUT.** Registered. On each `CLK_en` it takes the OR of rows 1–7 of the column `SCOL` will hold after that edge. Row 0 never contributes.
- **PA7_OUT.**
  - Manual mode: combinational, the key bit at (`PA_IN[6:4]`, `PA_IN[3:0]`).
  - Auto-scan: forced to 0.
- **Row 0.** Column 0 is SHIFT and column 1 is CTRL. Both are readable on `PA7_OUT` only.
- **Reset values.** All keys released, `SCOL`=0, `CA2_OUT`=0, `PA7_OUT`=0, `BREAK_OUT`=0, `KEY_READY`=0 while `RESET` is high and 1 from the first edge after release.
- **Reset mid-operation.** A pending handshake is dropped and the matrix is cleared. The source must re-offer the event.
- **Mode change.** Takes effect at the next `CLK_en`. `SCOL` keeps its value until then.

## Timing
- **Event to matrix.** An event accepted at edge N updates the matrix at edge N. A `PA7_OUT` read during the acceptance cycle sees the old state; the new state is visible from N+1.
- **Event to CA2.** The event affects `CA2_OUT` at the first `CLK_en` edge after N.
- **Simultaneous accept and `CLK_en`.** `CA2_OUT` uses the pre-update matrix.
- **PA7 latency.** 0 cycles from `PA_IN`, so the VIA can sample PORTA in its own read cycle.
- **Auto-scan cycle.** One column per `CLK_en`, 16 µs per full scan. A held key in a valid column asserts `CA2_OUT` for exactly one `CLK_en` period every 16.

## Configuration
- **`KBD_DIP_EN` defined:** row 0, columns 2–9 read as `key bit | DIP[col-2]` on `PA7_OUT`. Events still update these bits.
- **`KBD_DIP_EN` undefined:** those bits are pure key state and the `DIP` parameter is ignored.
- **Either way:** row 0 stays excluded from `CA2_OUT`.

## Structure
- Shared package `keyboard_pkg` holds:
  - `NUM_COLS`=10;
  - `BREAK_COL`=4'hF and `BREAK_ROW`=3'h0;
  - the `key_event_t` typedef {`row`,`col`,`make`};
  - named row/column constants for SHIFT and CTRL.
- One sub-module, `keyboard_scan_counter`, holds `SCOL`: load/increment on `CLK_en` and the mode mux.
- The matrix, event handshake, and `PA7`/`CA2` logic stay in `keyboard_matrix`.

## Test plan
- **Reset:** hold `RESET` for 3 cycles, then release → `CA2_OUT`=0, `PA7_OUT`=0, `BREAK_OUT`=0, `KEY_READY` rises 1 cycle after release, `SCOL`=0.
- **Manual read:** make (row 4, col 3), `KB_nEN`=0, `PA_IN`=7'h43 → `PA7_OUT`=1 the cycle after acceptance. `PA_IN`=7'h44 → `PA7_OUT`=0.
- **Auto-scan:** make (row 2, col 7), `KB_nEN`=1 → `CA2_OUT` high for exactly one `CLK_en` period, then low for 15 periods, repeating every 16. Break the key → `CA2_OUT` stays low.
- **Row 0 and DIP:** make SHIFT (row 0, col 0) in auto-scan → `CA2_OUT` never asserts. With `KBD_DIP_EN` and `DIP`=8'h01, `PA_IN`=7'h02 → `PA7_OUT`=1.
- **Back-to-back events and invalid columns:** hold `KEY_VALID` with 3 events → `KEY_READY` pattern 1,0,1,0,1 and all three are applied. Col 12 event → accepted, matrix unchanged. Col 15 row 0 make → `BREAK_OUT`=1.
- **Reset mid-handshake:** assert `RESET` while `KEY_VALID`=1 and `KEY_READY`=0 → the matrix clears immediately and the event is not applied after release.
